// File: rtl/step_pulse_gen_pkg.sv
// Shared types and constants for the step pulse generator.
package step_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_RUN
  } step_state_t;

  // Defaults for a 50 MHz system clock.
  localparam int unsigned DefDebounceCycles = 500_000;
  localparam int unsigned DefHoldCycles     = 25_000_000;
  localparam int unsigned DefRepeatCycles   = 5_000_000;
  localparam int unsigned DefRunPeriod      = 12_500_000;
  localparam int unsigned DefCntW           = 16;

  // Reduced values so simulation reaches every timer boundary quickly.
  localparam int unsigned SimDebounceCycles = 4;
  localparam int unsigned SimHoldCycles     = 10;
  localparam int unsigned SimRepeatCycles   = 3;
  localparam int unsigned SimRunPeriod      = 5;
  localparam int unsigned SimCntW           = 4;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen_key_debounce.sv
// Debounces the synchronized key level; flags the cycle on which the accepted level changes.
module key_debounce
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  output logic key_pressed,
  output logic key_rise,
  output logic key_fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            pressed_q, pressed_d;
  logic            toggle;

  assign cnt_inc = cnt_q + CntW'(1);

  // Count consecutive disagreeing samples; accept the new level when the count reaches the limit.
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    toggle    = 1'b0;
    if (key_level != pressed_q) begin
      if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
        toggle    = 1'b1;
        pressed_d = ~pressed_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // Edge strobes are combinational so the FSM can act on the same edge the level is accepted.
  assign key_pressed = pressed_q;
  assign key_rise    = toggle & ~pressed_q;
  assign key_fall    = toggle & pressed_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Single-cycle step pulse generator: manual press, hold-to-repeat, run mode, halt, step counter.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles,
  parameter int unsigned RUN_PERIOD      = DefRunPeriod,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             KeyLevel,
  input  logic             RunEn,
  input  logic             Halt,
  output logic             Step,
  output logic             KeyPressed,
  output logic             Running,
  output logic [CNT_W-1:0] StepCount
);

  localparam int unsigned TimerW =
      $clog2(max_of(max_of(DEBOUNCE_CYCLES, HOLD_CYCLES), max_of(REPEAT_CYCLES, RUN_PERIOD))) + 1;

  step_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d, timer_inc;
  logic              step_q, step_d;
  logic              running_q;
  logic [CNT_W-1:0]  count_q;
  logic              key_rise, key_fall;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk         (Clock),
    .rst         (Reset),
    .key_level   (KeyLevel),
    .key_pressed (KeyPressed),
    .key_rise    (key_rise),
    .key_fall    (key_fall)
  );

  assign timer_inc = timer_q + TimerW'(1);

  // Next state, shared interval timer and step request.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (RunEn) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (key_rise) begin
          step_d  = ~Halt;
          state_d = S_HOLD;
          timer_d = '0;
        end
      end
      S_HOLD: begin
        if (RunEn) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (key_fall) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_inc == TimerW'(HOLD_CYCLES)) begin
          step_d  = ~Halt;
          state_d = S_REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_REPEAT: begin
        if (RunEn) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (key_fall) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_inc == TimerW'(REPEAT_CYCLES)) begin
          step_d  = ~Halt;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RUN: begin
        if (!RunEn) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (!Halt) begin
          // Halt freezes the run timer rather than clearing it.
          if (timer_inc == TimerW'(RUN_PERIOD)) begin
            step_d  = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and registered outputs; the counter advances with each issued step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      running_q <= RunEn & ~Halt;
      if (step_d) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign Step      = step_q;
  assign Running   = running_q;
  assign StepCount = count_q;

endmodule
